// File: rtl/accumulator_drain_if.sv
// Row-stream output bus of the accumulator drain: one requantised row per beat,
// valid/ready handshake with row index and last marker.
interface accumulator_drain_if #(
   parameter int COLS      = 4,
   parameter int OUT_WIDTH = 8,
   parameter int ROW_W     = 2
);
   logic                             out_valid;
   logic                             out_ready;
   logic [COLS-1:0][OUT_WIDTH-1:0]   out_data;
   logic [ROW_W-1:0]                 out_row;
   logic                             out_last;

   modport master (output out_valid, out_data, out_row, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_row, out_last, output out_ready);
endinterface

// File: rtl/accumulator_drain.sv
// Snapshots the accumulator bank on start, clears it, then streams the snapshot
// one row per beat, requantised with round-half-up and saturation.
module accumulator_drain #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int ACC_WIDTH   = 32,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start_i,
   input  logic [SHIFT_WIDTH-1:0]                 shift_amt_i,
   input  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] accumulated_sums_i,
   input  logic                                   acc_overflow_i,
   output logic                                   acc_clear_o,
   output logic                                   busy_o,
   output logic                                   sat_flag_o,
   output logic                                   ovf_flag_o,
   output logic                                   done_o,
   accumulator_drain_if.master                    out_if
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
   localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_e;

   state_e                                  state_q;
   logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] snap_q;
   logic [SHIFT_WIDTH-1:0]                  shift_q;
   logic [ROW_W-1:0]                        row_q;
   logic                                    valid_q, clear_q, busy_q, done_q, sat_q, ovf_q;
   logic [COLS-1:0][OUT_WIDTH-1:0]          rq_data;
   logic [COLS-1:0]                         rq_clip;
   logic                                    last_row, xfer;

   // Returns {clipped, value}; the extra top bit keeps acc + rounding from wrapping.
   function automatic logic [OUT_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [SHIFT_WIDTH-1:0] s);
      logic signed [ACC_WIDTH:0] ext, rnd, v;
      ext = $signed({acc[ACC_WIDTH-1], acc});
      rnd = (s == '0) ? '0 : ({{ACC_WIDTH{1'b0}}, 1'b1} << (s - 1'b1));
      v   = (ext + rnd) >>> s;
      if (v > OMAX)      requant = {1'b1, OMAX[OUT_WIDTH-1:0]};
      else if (v < OMIN) requant = {1'b1, OMIN[OUT_WIDTH-1:0]};
      else               requant = {1'b0, v[OUT_WIDTH-1:0]};
   endfunction

   for (genvar j = 0; j < COLS; j++) begin : g_col
      assign {rq_clip[j], rq_data[j]} = requant(snap_q[row_q][j], shift_q);
   end

   assign last_row = (row_q == ROW_W'(ROWS - 1));
   assign xfer     = valid_q && out_if.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         shift_q <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         clear_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               snap_q  <= accumulated_sums_i;
               shift_q <= shift_amt_i;
               ovf_q   <= acc_overflow_i;
               sat_q   <= 1'b0;
               row_q   <= '0;
               clear_q <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= CLEAR;
            end
            CLEAR: begin
               clear_q <= 1'b0;
               valid_q <= 1'b1;
               state_q <= STREAM;
            end
            STREAM: if (xfer) begin
               sat_q <= sat_q | (|rq_clip);
               if (last_row) begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  row_q <= row_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign acc_clear_o      = clear_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign sat_flag_o       = sat_q;
   assign ovf_flag_o       = ovf_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = rq_data;
   assign out_if.out_row   = row_q;
   assign out_if.out_last  = valid_q && last_row;
endmodule
